seg_scan_controller: RTL and testbench
======================================

// Module: seg_scan_controller
// PURPOSE
// - Time-multiplexes N_DIGITS 7-segment digits through one shared external hex decoder
//   (4-bit nibble -> 7-bit active-low segments).
// - Sits between the Hamming datapath (corrected data, syndrome, etc.) and the board display.
// - Owns the anode scan, anti-ghosting blanking, and atomic per-frame update of the displayed value.
// PARAMETERS
// - N_DIGITS   4    number of multiplexed digits (2..8)
// - SHOW_CYC   6750 cycles a digit's anode stays on per slot (>=1)
// - BLANK_CYC  64   cycles all anodes off before each digit (>=2; covers decoder settle)
// PORTS
// - clk         in   1           system clock; single clock domain
// - rst         in   1           synchronous, active-high reset
// - load_valid  in   1           new display word offered
// - load_ready  out  1           controller can accept a word (pending buffer empty)
// - load_data   in   4*N_DIGITS  nibbles; digit i = load_data[4*i+3:4*i]
// - load_blank  in   N_DIGITS    1 = digit i kept dark (leading-zero suppression etc.)
// - dec_nibble  out  4           nibble presented to the shared decoder (registered)
// - dec_seg     in   7           decoder result, active-low, combinational from dec_nibble
// - seg         out  7           segment drive, active-low (registered)
// - an          out  N_DIGITS    anode enables, active-low, at most one bit low (registered)
// - frame_start out  1           1-cycle pulse on entry to digit 0's BLANK phase
// BEHAVIOUR
// - Reset (sync, rst=1 at a clk edge):
//   - seg=7'h7F, an=all 1, dec_nibble=0, frame_start=0, load_ready=1.
//   - state=BLANK, digit idx=0, phase counter=0.
//   - Active data=0, active blank mask=all 1 (dark until first commit). Pending buffer empty.
//   - rst mid-slot or mid-handshake aborts immediately; pending data is discarded.
// - FSM: BLANK -> SHOW -> BLANK(next digit) ...
//   - Each slot is BLANK_CYC + SHOW_CYC cycles.
//   - A frame is N_DIGITS slots. idx wraps N_DIGITS-1 -> 0.
// - BLANK phase, BLANK_CYC cycles:
//   - an=all 1.
//   - dec_nibble = active nibble[idx], registered on the BLANK entry edge.
//   - seg <= dec_seg on every BLANK cycle, so the last capture is settled.
// - SHOW phase, SHOW_CYC cycles:
//   - seg held.
//   - an[idx]=0 unless active_blank[idx]=1, in which case an stays all 1; slot timing is unchanged.
// - Frame boundary (transition into BLANK with idx=0):
//   - If pending is full, pending data and mask copy to active and pending empties, in the same edge.
//   - That first BLANK cycle already uses the new nibble[0].
//   - frame_start=1 for that one cycle.
// - Handshake:
//   - Accept on load_valid && load_ready at a clk edge; data goes into pending; load_ready=0 next cycle.
//   - load_ready returns to 1 the cycle after the commit edge.
//   - No bypass: a word accepted on a frame-boundary edge waits for the next frame.
//   - load_data and load_blank are sampled only on accept.
//   - load_valid while load_ready=0 is ignored; no stall or error.
// - Display never shows a torn word: active data changes only at frame boundaries.
// - Counters:
//   - Phase counter width is $clog2(max(SHOW_CYC,BLANK_CYC)).
//   - idx width is $clog2(N_DIGITS).
//   - No counter overflows or wraps except idx at N_DIGITS-1.
// STRUCTURE
// - Shared package seg_pkg:
//   - SEG_OFF = 7'h7F.
//   - scan_state_e {BLANK, SHOW}.
//   - Helper localparams for counter widths.
// - Sub-module seg_phase_timer:
//   - Loadable down-counter with a done pulse.
//   - Instantiated once and reloaded with BLANK_CYC-1 or SHOW_CYC-1 on each phase change.
// - Shared hex decoder stays outside, wired via dec_nibble/dec_seg at the top level.
// TESTING (bench: N_DIGITS=4, BLANK_CYC=2, SHOW_CYC=4 -> slot 6, frame 24 cycles; ideal hex decoder model)
// - Reset release:
//   - an=4'hF and seg=7'h7F for the whole first frame (mask all 1).
//   - load_ready=1.
//   - frame_start pulses at cycles 0, 24, 48 after reset.
// - Load 16'h3A21, blank=0 mid-frame 0:
//   - load_ready drops next cycle.
//   - From frame 1: an cycles 1110,1101,1011,0111.
//   - seg reads 7'h79 ("1"), 7'h24 ("2"), 7'h08 ("A"), 7'h30 ("3"), each held 4 cycles.
//   - an=1111 for 2 cycles between digits; load_ready back to 1 the cycle after commit.
// - Back-to-back loads:
//   - Second load_valid while pending is full is ignored, and the display keeps the first word.
//   - A load accepted exactly on a frame-boundary edge shows one frame later.
// - Blank mask 4'b1000 with 16'h0042:
//   - Digit 3's SHOW slot has an=1111; other digits are timed identically.
// - Assert rst for 1 cycle mid-SHOW of digit 2 with pending full:
//   - Next cycle an=1111, seg=7'h7F, idx=0, load_ready=1.
//   - Display stays dark until a new load commits.
// - Assertions on every cycle:
//   - $countones(~an) <= 1.
//   - an never changes in the same cycle as seg.
//   - Idle display shows no X on seg/an.

Source files
------------

// File: rtl/seg_pkg.sv
// Purpose: shared constants, scan-state encoding and counter-width helper for the 7-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_pkg;

    // Active-low segment pattern with every segment dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Width of the shared phase counter. It must hold max(SHOW_CYC, BLANK_CYC)-1.
    // The width is never less than one bit, so a 1-cycle phase still gets a real register.
    function automatic int cnt_width(input int show_cyc, input int blank_cyc);
        int m;
        int w;
        m = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Purpose: loadable down-counter that times the BLANK and SHOW phases of one digit slot.
// Latency: done is combinational from the count; a load takes effect on the next edge.
// Backpressure: none; a load always overrides the count.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset (count clears to 0)
//   load, load_val   reload the counter with load_val (phase length - 1)
//   done             high while the count is 0, i.e. the last cycle of the phase
module seg_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// Purpose: time-multiplexes N_DIGITS 7-segment digits through one external hex decoder, with blanking between digits.
// Latency: a word that is accepted is shown from the next frame boundary. All display outputs are registered.
// Backpressure: load_ready is low while a word is pending. load_valid is ignored (no stall) until that word commits.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   load_valid/load_ready    valid-ready handshake for a new display word
//   load_data, load_blank    nibble i = load_data[4*i+3:4*i]; load_blank[i]=1 keeps digit i dark
//   dec_nibble -> dec_seg    round trip through the shared combinational hex decoder (active-low result)
//   seg, an                  active-low segment and anode drive; at most one anode is low
//   frame_start              one-cycle pulse in the first BLANK cycle of digit 0
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SHOW_CYC  = 6750,
    parameter int BLANK_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_data,
    input  logic [N_DIGITS-1:0]   load_blank,
    output logic [3:0]            dec_nibble,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int CNT_W = cnt_width(SHOW_CYC, BLANK_CYC);
    localparam int IDX_W = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0]    BLANK_LD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0]    SHOW_LD  = CNT_W'(SHOW_CYC - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = '1;

    scan_state_e           state;
    logic [IDX_W-1:0]      idx;
    // Set by reset. The first edge after reset then starts frame 0 cleanly,
    // which gives frame_start and a full-length BLANK for digit 0.
    logic                  boot;

    logic [4*N_DIGITS-1:0] act_data;
    logic [N_DIGITS-1:0]   act_blank;
    logic [4*N_DIGITS-1:0] pend_data;
    logic [N_DIGITS-1:0]   pend_blank;
    logic                  pend_full;

    logic                  phase_done;
    logic                  phase_load;
    logic [CNT_W-1:0]      phase_val;

    logic                  enter_blank;
    logic                  enter_show;
    logic [IDX_W-1:0]      next_idx;
    logic                  frame_entry;
    logic                  commit;
    logic                  accept;
    logic [4*N_DIGITS-1:0] src_data;
    logic [3:0]            src_nib [N_DIGITS];
    logic [3:0]            next_nibble;
    logic [N_DIGITS-1:0]   an_show;

    // Slot sequencing: BLANK -> SHOW -> BLANK of the next digit.
    always_comb begin
        enter_blank = 1'b0;
        enter_show  = 1'b0;
        next_idx    = idx;
        if (boot) begin
            enter_blank = 1'b1;
            next_idx    = '0;
        end else if (phase_done) begin
            if (state == BLANK) begin
                enter_show = 1'b1;
            end else begin
                enter_blank = 1'b1;
                next_idx    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    assign frame_entry = enter_blank && (next_idx == '0);
    assign commit      = frame_entry && pend_full;
    // commit and accept are mutually exclusive (pend_full selects one of them).
    // A word offered on a frame-boundary edge therefore waits a full frame.
    assign accept      = load_valid && !pend_full;
    assign load_ready  = !pend_full;

    // The first BLANK cycle of a frame must already present the newly committed nibble.
    assign src_data = commit ? pend_data : act_data;

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            src_nib[i] = src_data[4*i +: 4];
        end
    end

    assign next_nibble = src_nib[next_idx];
    assign an_show     = act_blank[idx] ? AN_OFF : ~(N_DIGITS'(1) << idx);

    assign phase_load = enter_blank || enter_show;
    assign phase_val  = enter_show ? SHOW_LD : BLANK_LD;

    seg_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_val),
        .done     (phase_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            idx         <= '0;
            boot        <= 1'b1;
            act_data    <= '0;
            act_blank   <= '1;
            pend_data   <= '0;
            pend_blank  <= '0;
            pend_full   <= 1'b0;
            dec_nibble  <= '0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            boot        <= 1'b0;
            frame_start <= frame_entry;

            // Capture on every BLANK cycle, so the value that SHOW holds comes from a settled decoder.
            // seg only changes while all anodes are off.
            if (state == BLANK) begin
                seg <= act_blank[idx] ? SEG_OFF : dec_seg;
            end

            if (enter_blank) begin
                state      <= BLANK;
                idx        <= next_idx;
                an         <= AN_OFF;
                dec_nibble <= next_nibble;
            end else if (enter_show) begin
                state <= SHOW;
                an    <= an_show;
            end

            if (commit) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_data  <= load_data;
                pend_blank <= load_blank;
                pend_full  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Purpose: self-checking bench for seg_scan_controller (N_DIGITS=4, BLANK_CYC=2, SHOW_CYC=4).
// Latency: a slot is 6 cycles and a frame is 24 cycles. Outputs are sampled on the falling edge.
// Backpressure: exercises ignored load_valid while a word is pending, and a load exactly on a frame boundary.
module tb_seg_scan_controller;

    localparam int FRAME = 24;
    localparam int SLOT  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_blank;
    logic [3:0]  dec_nibble;
    logic [6:0]  dec_seg;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Ideal external hex decoder, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign dec_seg = hex7(dec_nibble);

    seg_scan_controller #(
        .N_DIGITS  (4),
        .SHOW_CYC  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_blank  (load_blank),
        .dec_nibble  (dec_nibble),
        .dec_seg     (dec_seg),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] exp_seg;  // indexed by digit
        logic [3:0][3:0] exp_an;   // anode pattern during that digit's SHOW
    } vec_t;

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] b,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3);
        vec_t v;
        v.data  = d;
        v.blank = b;
        v.exp_seg[0] = s0; v.exp_seg[1] = s1; v.exp_seg[2] = s2; v.exp_seg[3] = s3;
        v.exp_an[0]  = a0; v.exp_an[1]  = a1; v.exp_an[2]  = a2; v.exp_an[3]  = a3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to cycle 0 of the next frame, bounded to a little over two frames.
    task automatic wait_frame();
        int k = 0;
        step();
        while (frame_start !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    // Called at cycle 0 of a frame. Returns at cycle 23 of the same frame.
    task automatic check_frame(input vec_t v, input string tag);
        int d;
        int t;
        logic [3:0] nib;
        for (int c = 0; c < FRAME; c++) begin
            d = c / SLOT;
            t = c % SLOT;
            nib = v.data[4*d +: 4];
            chk({"frame_start_", tag}, 32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
            chk({"an_", tag}, 32'(an), (t < 2) ? 32'hF : 32'(v.exp_an[d]));
            if (t >= 1) chk({"seg_", tag}, 32'(seg), 32'(v.exp_seg[d]));
            if (t == 1) chk({"dec_nibble_", tag}, 32'(dec_nibble), 32'(nib));
            if (c < FRAME - 1) step();
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        wait_frame();
        repeat (5) step();
        chk({"ready_before_", tag}, 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = v.data;
        load_blank = v.blank;
        step();
        chk({"ready_drop_", tag}, 32'(load_ready), 32'd0);
        // Garbage after the accept must not leak into the display.
        load_valid = 1'b0;
        load_data  = 16'hFFFF;
        load_blank = 4'hF;
        wait_frame();
        chk({"ready_back_", tag}, 32'(load_ready), 32'd1);
        check_frame(v, tag);
    endtask

    // Checks on every cycle once reset has been applied.
    logic       rst_seen = 1'b1;
    logic       armed    = 1'b0;
    logic [3:0] prev_an;
    logic [6:0] prev_seg;

    always @(posedge clk) begin
        rst_seen <= rst;
        if (rst) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("no_x", 32'($isunknown({an, seg})), 32'd0);
            chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
            if (!rst_seen) begin
                chk("an_seg_same_cycle", 32'((an !== prev_an) && (seg !== prev_seg)), 32'd0);
            end
            prev_an  = an;
            prev_seg = seg;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    vec_t tbl [3];
    vec_t w1;
    vec_t w3;

    initial begin
        tbl[0] = mk(16'h3A21, 4'b0000, 7'h79, 7'h24, 7'h08, 7'h30, 4'hE, 4'hD, 4'hB, 4'h7);
        tbl[1] = mk(16'h0042, 4'b1000, 7'h24, 7'h19, 7'h40, 7'h7F, 4'hE, 4'hD, 4'hB, 4'hF);
        tbl[2] = mk(16'h7B60, 4'b0011, 7'h7F, 7'h7F, 7'h03, 7'h78, 4'hF, 4'hF, 4'hB, 4'h7);
        w1     = mk(16'h5555, 4'b0000, 7'h12, 7'h12, 7'h12, 7'h12, 4'hE, 4'hD, 4'hB, 4'h7);
        w3     = mk(16'h2222, 4'b0000, 7'h24, 7'h24, 7'h24, 7'h24, 4'hE, 4'hD, 4'hB, 4'h7);

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_blank = 4'h0;
        repeat (3) step();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_dec_nibble", 32'(dec_nibble), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;

        // Three dark frames. frame_start is expected on cycles 0, 24 and 48.
        for (int c = 0; c < 3 * FRAME; c++) begin
            step();
            chk("boot_frame_start", 32'(frame_start), (c % FRAME == 0) ? 32'd1 : 32'd0);
            chk("boot_an", 32'(an), 32'hF);
            chk("boot_seg", 32'(seg), 32'h7F);
            chk("boot_ready", 32'(load_ready), 32'd1);
        end

        for (int i = 0; i < 3; i++) begin
            run_vector(tbl[i], $sformatf("vec%0d", i));
        end

        // A second word offered while the first is pending is ignored.
        wait_frame();
        repeat (3) step();
        load_valid = 1'b1;
        load_data  = w1.data;
        load_blank = w1.blank;
        step();
        chk("b2b_ready_drop", 32'(load_ready), 32'd0);
        load_data = 16'h9999;
        repeat (4) step();
        load_valid = 1'b0;
        wait_frame();
        chk("b2b_ready_back", 32'(load_ready), 32'd1);
        check_frame(w1, "b2b_first");

        // A word accepted on the frame-boundary edge waits one full frame.
        load_valid = 1'b1;
        load_data  = w3.data;
        load_blank = w3.blank;
        chk("edge_ready_pre", 32'(load_ready), 32'd1);
        step();
        chk("edge_frame_start", 32'(frame_start), 32'd1);
        chk("edge_accepted", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        check_frame(w1, "edge_old");
        wait_frame();
        chk("edge_ready_back", 32'(load_ready), 32'd1);
        check_frame(w3, "edge_new");

        // Reset during digit 2's SHOW with a word pending. The pending word is discarded.
        wait_frame();
        repeat (3) step();
        load_valid = 1'b1;
        load_data  = 16'h4444;
        load_blank = 4'h0;
        step();
        chk("mid_rst_pending", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        repeat (11) step();
        chk("mid_rst_digit2_on", 32'(an), 32'hB);
        rst = 1'b1;
        step();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_ready", 32'(load_ready), 32'd1);
        chk("mid_rst_dec_nibble", 32'(dec_nibble), 32'd0);
        chk("mid_rst_frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            chk("post_rst_frame_start", 32'(frame_start), (c % FRAME == 0) ? 32'd1 : 32'd0);
            chk("post_rst_an", 32'(an), 32'hF);
            chk("post_rst_seg", 32'(seg), 32'h7F);
        end
        run_vector(tbl[0], "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
